// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory read-port arbiter.
package mem_arb_pkg;

    localparam int unsigned STATE_W            = 2;
    localparam int unsigned DEF_NUM_REQ        = 2;
    localparam int unsigned DEF_ADDR_WIDTH     = 64;
    localparam int unsigned DEF_DATA_WIDTH     = 64;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rd_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: the first requester after ptr
// (cyclically) wins; returns both a one-hot grant and its index.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    assign any = |req;

    // Scan requesters starting just after the pointer, keep the first hit.
    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_REQ requesters,
// one outstanding read at a time, response routed to the granted requester.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (abandons a read after
// TIMEOUT_CYCLES in ISSUE and answers with resp_err=1, resp_data=0).
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH*2-1:0]       resp_data,
    output logic                          resp_err,
    output logic                          ren_mem,
    output logic [ADDR_WIDTH-1:0]         raddr_mem,
    input  logic                          rvalid_mem,
    input  logic [DATA_WIDTH*2-1:0]       rdata_mem
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        rr_ptr, rr_ptr_nxt, pick_idx;
    logic [NUM_REQ-1:0]      pick_onehot;
    logic                    pick_any;
    logic                    issue_end;
    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

    logic [NUM_REQ-1:0]      grant_nxt, resp_valid_nxt;
    logic [DATA_WIDTH*2-1:0] resp_data_nxt;
    logic                    ren_nxt;
    logic [ADDR_WIDTH-1:0]   raddr_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_onehot),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Unpack the flat address bus into per-requester slices.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic             resp_err_nxt;

    assign timed_out = (state == ST_ISSUE) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign issue_end = rvalid_mem || timed_out;

    // Count cycles spent in ISSUE since the grant; cleared everywhere else.
    always_ff @(posedge clk) begin
        if (!rstn || state != ST_ISSUE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Error flag accompanies resp_valid only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_err <= 1'b0;
        end else begin
            resp_err <= resp_err_nxt;
        end
    end
`else
    assign issue_end = rvalid_mem;
    assign resp_err  = 1'b0;
`endif

    // State register plus the registered outputs computed below.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            req_grant  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            ren_mem    <= 1'b0;
            raddr_mem  <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            req_grant  <= grant_nxt;
            resp_valid <= resp_valid_nxt;
            resp_data  <= resp_data_nxt;
            ren_mem    <= ren_nxt;
            raddr_mem  <= raddr_nxt;
        end
    end

    // Next-state: IDLE -> ISSUE on any request, ISSUE -> DONE on response, DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (pick_any)  state_nxt = ST_ISSUE;
            ST_ISSUE: if (issue_end) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next output values; rr_ptr doubles as the current owner's index while in ISSUE.
    always_comb begin
        grant_nxt      = req_grant;
        ren_nxt        = ren_mem;
        raddr_nxt      = raddr_mem;
        resp_valid_nxt = '0;
        resp_data_nxt  = resp_data;
        rr_ptr_nxt     = rr_ptr;
`ifdef MEM_ARB_TIMEOUT_EN
        resp_err_nxt   = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nxt  = pick_onehot;
                    ren_nxt    = 1'b1;
                    raddr_nxt  = addr_arr[pick_idx];
                    rr_ptr_nxt = pick_idx;
                end else begin
                    grant_nxt = '0;
                    ren_nxt   = 1'b0;
                    raddr_nxt = '0;
                end
            end
            ST_ISSUE: begin
                if (rvalid_mem) begin
                    resp_valid_nxt = req_grant;
                    resp_data_nxt  = rdata_mem;
                    grant_nxt      = '0;
                    ren_nxt        = 1'b0;
                    raddr_nxt      = '0;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    resp_valid_nxt = req_grant;
                    resp_data_nxt  = '0;
                    resp_err_nxt   = 1'b1;
                    grant_nxt      = '0;
                    ren_nxt        = 1'b0;
                    raddr_nxt      = '0;
                end
`endif
            end
            default: begin
                grant_nxt = '0;
                ren_nxt   = 1'b0;
                raddr_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboard bench for mem_rd_arbiter (NUM_REQ=2, 64-bit address, 128-bit data).
// Define MEM_ARB_TIMEOUT_EN to also cover the timeout path (TIMEOUT_CYCLES=8).
module tb_mem_rd_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic [1:0]   req_valid;
    logic [127:0] req_addr;
    logic [1:0]   req_grant;
    logic [1:0]   resp_valid;
    logic [127:0] resp_data;
    logic         resp_err;
    logic         ren_mem;
    logic [63:0]  raddr_mem;
    logic         rvalid_mem;
    logic [127:0] rdata_mem;

    typedef struct {
        logic [1:0]  grant;
        logic [63:0] addr;
    } grant_exp_t;

    typedef struct {
        logic [1:0]   valid;
        logic [127:0] data;
        logic         err;
    } resp_exp_t;

    grant_exp_t grant_q[$];
    resp_exp_t  resp_q[$];

    int checks   = 0;
    int failures = 0;
    int lat;

    mem_rd_arbiter #(
        .NUM_REQ        (2),
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_grant  (req_grant),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .ren_mem    (ren_mem),
        .raddr_mem  (raddr_mem),
        .rvalid_mem (rvalid_mem),
        .rdata_mem  (rdata_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a grant starts or a response appears.
    initial begin : monitor
        logic       ren_prev;
        grant_exp_t g;
        resp_exp_t  r;
        ren_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_valid !== 2'b00) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected actual=%0h required=none", resp_valid);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_valid", 128'(resp_valid), 128'(r.valid));
                    check("resp_data", resp_data, r.data);
                    check("resp_err", 128'(resp_err), 128'(r.err));
                end
            end
            if (ren_mem === 1'b1 && ren_prev === 1'b0) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected actual=%0h required=none", req_grant);
                end else begin
                    g = grant_q.pop_front();
                    check("req_grant", 128'(req_grant), 128'(g.grant));
                    check("raddr_mem", 128'(raddr_mem), 128'(g.addr));
                end
            end
            ren_prev = ren_mem;
        end
    end

    // Expect a grant; returns the number of negedges until ren_mem rose.
    task automatic wait_grant(input logic [1:0] g, input logic [63:0] a, output int n);
        grant_q.push_back('{grant: g, addr: a});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ren_mem !== 1'b1 && n < 30);
        if (ren_mem !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout actual=%0h required=%0h", req_grant, g);
        end
    endtask

    // After `delay` further ISSUE cycles pulse rvalid_mem with data for owner g.
    task automatic respond(input logic [1:0] g, input logic [127:0] d, input int delay);
        repeat (delay) @(negedge clk);
        rvalid_mem = 1'b1;
        rdata_mem  = d;
        resp_q.push_back('{valid: g, data: d, err: 1'b0});
        @(negedge clk);
        rvalid_mem = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rstn       = 1'b0;
        req_valid  = 2'b00;
        req_addr   = '0;
        rvalid_mem = 1'b0;
        rdata_mem  = '0;
        @(negedge clk);
        do_reset();

        // Reset state, sampled before any request arrives.
        check("rst_ren", 128'(ren_mem), 128'(0));
        check("rst_grant", 128'(req_grant), 128'(0));
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_raddr", 128'(raddr_mem), 128'(0));

        // Single request; rvalid in the 3rd ISSUE cycle; address change after grant ignored.
        req_addr[63:0] = 64'h0000_0000_8000_1000;
        req_valid      = 2'b01;
        wait_grant(2'b01, 64'h0000_0000_8000_1000, lat);
        check("single_grant_latency", 128'(lat), 128'(1));
        req_addr[63:0] = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        check("raddr_held", 128'(raddr_mem), 128'h8000_1000);
        respond(2'b01, {16{8'hA5}}, 1);
        check("single_resp_valid", 128'(resp_valid), 128'(2'b01));
        check("single_ren_clear", 128'(ren_mem), 128'(0));
        req_valid = 2'b00;
        @(negedge clk);
        check("single_resp_pulse", 128'(resp_valid), 128'(0));
        repeat (2) @(negedge clk);

        // Simultaneous requests from reset: 0 then 1, twice.
        req_addr  = {64'h0000_0000_0000_A100, 64'h0000_0000_0000_A000};
        req_valid = 2'b11;
        do_reset();
        wait_grant(2'b01, 64'hA000, lat);
        respond(2'b01, 128'h1111_0000, 1);
        req_valid[0] = 1'b0;
        wait_grant(2'b10, 64'hA100, lat);
        check("b2b_grant_latency", 128'(lat), 128'(2));
        respond(2'b10, 128'h2222_0000, 0);
        req_valid[1] = 1'b0;
        @(negedge clk);
        req_valid = 2'b11;
        wait_grant(2'b01, 64'hA000, lat);
        respond(2'b01, 128'h3333_0000, 2);
        req_valid[0] = 1'b0;
        wait_grant(2'b10, 64'hA100, lat);
        respond(2'b10, 128'h4444_0000, 0);
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Fairness: requester 0 held, requester 1 raised during 0's service.
        req_addr  = {64'h0000_0000_0000_B100, 64'h0000_0000_0000_B000};
        req_valid = 2'b01;
        wait_grant(2'b01, 64'hB000, lat);
        req_valid[1] = 1'b1;
        respond(2'b01, 128'h5555_0000, 1);
        wait_grant(2'b10, 64'hB100, lat);
        check("fair_grant_latency", 128'(lat), 128'(2));
        respond(2'b10, 128'h6666_0000, 0);
        req_valid[1] = 1'b0;
        wait_grant(2'b01, 64'hB000, lat);
        respond(2'b01, 128'h7777_0000, 0);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        // Stray rvalid_mem in IDLE must be ignored.
        rvalid_mem = 1'b1;
        rdata_mem  = '1;
        @(negedge clk);
        rvalid_mem = 1'b0;
        check("stray_ren", 128'(ren_mem), 128'(0));
        @(negedge clk);
        check("stray_resp_valid", 128'(resp_valid), 128'(0));
        check("stray_ren2", 128'(ren_mem), 128'(0));

        // Reset during ISSUE abandons the read; held request is served afterwards.
        req_addr[63:0] = 64'h0000_0000_0000_C000;
        req_valid      = 2'b01;
        wait_grant(2'b01, 64'hC000, lat);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_ren", 128'(ren_mem), 128'(0));
        check("midrst_grant", 128'(req_grant), 128'(0));
        check("midrst_resp_valid", 128'(resp_valid), 128'(0));
        rstn = 1'b1;
        wait_grant(2'b01, 64'hC000, lat);
        check("rerequest_latency", 128'(lat), 128'(1));
        respond(2'b01, 128'h8888_0000, 1);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // No rvalid: timeout answer with error and zero data; late rvalid dropped.
        req_addr[63:0] = 64'h0000_0000_0000_E000;
        req_valid      = 2'b01;
        wait_grant(2'b01, 64'hE000, lat);
        resp_q.push_back('{valid: 2'b01, data: '0, err: 1'b1});
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid === 2'b00 && lat < 30);
        check("timeout_seen", 128'(resp_valid), 128'(2'b01));
        req_valid  = 2'b00;
        rvalid_mem = 1'b1;
        rdata_mem  = 128'hBAD;
        @(negedge clk);
        rvalid_mem = 1'b0;
        repeat (3) @(negedge clk);
        check("late_rvalid_ren", 128'(ren_mem), 128'(0));
`endif

        repeat (3) @(negedge clk);
        check("grant_q_empty", 128'(grant_q.size()), 128'(0));
        check("resp_q_empty", 128'(resp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
